// File: rtl/pc_sequencer_if.sv
// Fetch-PC sequencer bundle: the pipeline control requests that steer the PC
// and the fetch-side status the sequencer publishes back.
//   master : pipeline/hazard side, drives the requests and observes fetch status
//   slave  : the sequencer, consumes the requests and drives pc/flush/status
interface pc_sequencer_if #(
  parameter int unsigned N = 32
);
  // requests into the sequencer
  logic         stall;
  logic         jump;
  logic [N-1:0] jump_target;
  logic         branch_taken;
  logic [N-1:0] branch_target;
  logic         exception;
  logic         halt;
  logic         resume;

  // fetch status out of the sequencer
  logic [N-1:0] pc;
  logic [N-1:0] pc_plus4;
  logic         fetch_valid;
  logic         flush_if_id;
  logic         flush_id_ex;
  logic [1:0]   state;
  logic [15:0]  redirect_count;

  modport master (
    output stall, jump, jump_target, branch_taken, branch_target,
           exception, halt, resume,
    input  pc, pc_plus4, fetch_valid, flush_if_id, flush_id_ex,
           state, redirect_count
  );

  modport slave (
    input  stall, jump, jump_target, branch_taken, branch_target,
           exception, halt, resume,
    output pc, pc_plus4, fetch_valid, flush_if_id, flush_id_ex,
           state, redirect_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: picks the next fetch PC from exception/branch/jump/halt/stall requests.
// Latency: pc, fetch_valid, state, redirect_count update on the next clk edge; flushes and pc_plus4 are combinational.
// Backpressure: stall holds pc and fetch_valid; any redirect overrides a simultaneous stall.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous, active-high; restores RESET_PC / RUN / fetch_valid=1 / count=0
//   bus    - pc_sequencer_if.slave: stall, jump(+target), branch_taken(+target), exception,
//            halt, resume in; pc, pc_plus4, fetch_valid, flush_if_id, flush_id_ex, state,
//            redirect_count out
module pc_sequencer #(
  parameter int unsigned  N          = 32,
  parameter logic [N-1:0] RESET_PC   = 32'h0040_0000,
  parameter logic [N-1:0] EXC_VECTOR = 32'h0040_0180
) (
  input logic           clk,
  input logic           reset,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    HALTED   = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  // The single event accepted this cycle after priority resolution.
  typedef enum logic [2:0] {
    EV_IDLE   = 3'd0,  // nothing changes (reset cycle, or HALTED with no exit)
    EV_EXC    = 3'd1,
    EV_BRANCH = 3'd2,
    EV_JUMP   = 3'd3,
    EV_HALT   = 3'd4,
    EV_STALL  = 3'd5,
    EV_SEQ    = 3'd6   // sequential fetch, also used for resume from HALTED
  } event_t;

  state_t       state_reg;
  state_t       state_next;
  logic [N-1:0] pc_reg;
  logic [N-1:0] pc_next;
  logic [N-1:0] pc_inc;
  logic         fetch_valid_reg;
  logic         fetch_valid_next;
  logic [15:0]  count_reg;
  logic         misaligned;
  logic         redirect;
  logic         flush_if_id;
  logic         flush_id_ex;
  event_t       ev;

  // Wraps naturally at 2^N, so fetch continues from 0 after the top word.
  assign pc_inc = pc_reg + N'(4);

  // A taken branch to a non-word address is treated as an exception.
  assign misaligned = bus.branch_taken && (bus.branch_target[1:0] != 2'b00);

  // ---------------------------------------------------------------------------
  // Event priority resolution
  // ---------------------------------------------------------------------------
  always_comb begin
    ev = EV_IDLE;
    if (reset) begin
      // Registers are reset in the sequential block; the event is forced idle
      // so that no flush is requested during reset.
      ev = EV_IDLE;
    end else if (state_reg == HALTED) begin
      // Only exception and resume are seen while halted; exception wins.
      if (bus.exception) begin
        ev = EV_EXC;
      end else if (bus.resume) begin
        ev = EV_SEQ;
      end
    end else begin
      // RUN and REDIRECT (and the unused encoding) share one priority chain.
      if (bus.exception || misaligned) begin
        ev = EV_EXC;
      end else if (bus.branch_taken) begin
        ev = EV_BRANCH;
      end else if (bus.jump) begin
        ev = EV_JUMP;
      end else if (bus.halt) begin
        ev = EV_HALT;
      end else if (bus.stall) begin
        ev = EV_STALL;
      end else begin
        ev = EV_SEQ;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / output decode for the accepted event
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_next          = pc_reg;
    state_next       = state_reg;
    fetch_valid_next = fetch_valid_reg;
    flush_if_id      = 1'b0;
    flush_id_ex      = 1'b0;
    redirect         = 1'b0;

    case (ev)
      EV_EXC: begin
        pc_next     = EXC_VECTOR;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        redirect    = 1'b1;
      end
      EV_BRANCH: begin
        pc_next     = bus.branch_target;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        redirect    = 1'b1;
      end
      EV_JUMP: begin
        // The jump sits in ID, so only the younger IF/ID instruction dies.
        pc_next     = bus.jump_target;
        flush_if_id = 1'b1;
        redirect    = 1'b1;
      end
      EV_HALT: begin
        flush_if_id      = 1'b1;
        state_next       = HALTED;
        fetch_valid_next = 1'b0;
      end
      EV_STALL: begin
        // PC and fetch_valid are held. REDIRECT is a one-cycle marker, so a
        // stall arriving in it still drops back to RUN; from RUN this is a hold.
        state_next = RUN;
      end
      EV_SEQ: begin
        pc_next          = pc_inc;
        state_next       = RUN;
        fetch_valid_next = 1'b1;
      end
      default: begin
      end
    endcase

    // Every accepted redirect fetches a valid instruction at the new target.
    if (redirect) begin
      state_next       = REDIRECT;
      fetch_valid_next = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= RUN;
      pc_reg          <= RESET_PC;
      fetch_valid_reg <= 1'b1;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      fetch_valid_reg <= fetch_valid_next;
    end
  end

  // Saturating count of accepted exception/branch/jump redirects.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= 16'd0;
    end else if (redirect && (count_reg != 16'hFFFF)) begin
      count_reg <= count_reg + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.pc             = pc_reg;
  assign bus.pc_plus4       = pc_inc;
  assign bus.fetch_valid    = fetch_valid_reg;
  assign bus.flush_if_id    = flush_if_id;
  assign bus.flush_id_ex    = flush_id_ex;
  assign bus.state          = state_reg;
  assign bus.redirect_count = count_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam int S_RUN      = 0;
  localparam int S_HALTED   = 1;
  localparam int S_REDIRECT = 2;
  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] EXC_PC = 32'h0040_0180;

  logic clk;
  logic reset;

  pc_sequencer_if #(.N(32)) bus ();

  pc_sequencer #(.N(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: architectural state after the most recent edge.
  // ---------------------------------------------------------------------------
  bit          m_valid = 0;
  logic [31:0] m_pc;
  int          m_st;
  logic        m_fv;
  int          m_cnt;

  logic        e_fi, e_fe;
  logic [31:0] n_pc;
  int          n_st;
  logic        n_fv;
  int          n_cnt;
  int          kind;   // 0 none, 1 exc, 2 branch, 3 jump, 4 halt, 5 stall, 6 seq

  // Inputs change only at posedge+1, so on the falling edge they are exactly
  // what the next rising edge will sample.
  always @(negedge clk) begin
    kind = 0;
    if (reset) kind = 0;
    else if (m_st == S_HALTED) begin
      if (bus.exception) kind = 1;
      else if (bus.resume) kind = 6;
    end else begin
      if (bus.exception || (bus.branch_taken && bus.branch_target[1:0] != 2'b00)) kind = 1;
      else if (bus.branch_taken) kind = 2;
      else if (bus.jump) kind = 3;
      else if (bus.halt) kind = 4;
      else if (bus.stall) kind = 5;
      else kind = 6;
    end

    e_fi = (kind >= 1 && kind <= 4);
    e_fe = (kind == 1 || kind == 2);

    if (m_valid) begin
      chk("pc", bus.pc, m_pc);
      chk("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
      chk("fetch_valid", {31'd0, bus.fetch_valid}, {31'd0, m_fv});
      chk("state", {30'd0, bus.state}, m_st);
      chk("redirect_count", {16'd0, bus.redirect_count}, m_cnt);
      chk("flush_if_id", {31'd0, bus.flush_if_id}, {31'd0, e_fi});
      chk("flush_id_ex", {31'd0, bus.flush_id_ex}, {31'd0, e_fe});
    end

    n_pc = m_pc; n_st = m_st; n_fv = m_fv; n_cnt = m_cnt;
    if (reset) begin
      n_pc = RST_PC; n_st = S_RUN; n_fv = 1'b1; n_cnt = 0;
    end else begin
      case (kind)
        1: n_pc = EXC_PC;
        2: n_pc = bus.branch_target;
        3: n_pc = bus.jump_target;
        4: begin n_st = S_HALTED; n_fv = 1'b0; end
        5: n_st = S_RUN;
        6: begin n_pc = m_pc + 32'd4; n_st = S_RUN; n_fv = 1'b1; end
        default: ;
      endcase
      if (kind >= 1 && kind <= 3) begin
        n_st = S_REDIRECT;
        n_fv = 1'b1;
        n_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      end
    end
    if (reset) m_valid = 1;
    m_pc = n_pc; m_st = n_st; m_fv = n_fv; m_cnt = n_cnt;
  end

  // ---------------------------------------------------------------------------
  // Stimulus with hand-computed anchor checks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.stall = 0; bus.jump = 0; bus.jump_target = '0;
    bus.branch_taken = 0; bus.branch_target = '0;
    bus.exception = 0; bus.halt = 0; bus.resume = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    reset = 0;
  endtask

  logic [31:0] t;

  initial begin
    clear_in();
    reset = 1;
    bus.branch_taken = 1; bus.branch_target = 32'h0040_0100; bus.exception = 1;
    tick();
    // flushes stay low while reset is asserted, whatever the requests
    #1;
    chk("reset_flush_if_id", {31'd0, bus.flush_if_id}, 32'd0);
    chk("reset_flush_id_ex", {31'd0, bus.flush_id_ex}, 32'd0);
    tick();
    reset = 0;
    clear_in();
    chk("reset_pc", bus.pc, 32'h0040_0000);
    chk("reset_state", {30'd0, bus.state}, 32'd0);
    chk("reset_fv", {31'd0, bus.fetch_valid}, 32'd1);
    chk("reset_cnt", {16'd0, bus.redirect_count}, 32'd0);

    // idle sequential fetch
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("seq_pc", bus.pc, 32'h0040_0000 + 32'(4 * i));
    end
    chk("seq_fv", {31'd0, bus.fetch_valid}, 32'd1);

    // branch overriding a two-cycle stall
    do_reset();
    tick(); tick();
    chk("pre_branch_pc", bus.pc, 32'h0040_0008);
    bus.stall = 1; bus.branch_taken = 1; bus.branch_target = 32'h0040_0100;
    #1;
    chk("br_flush_if_id", {31'd0, bus.flush_if_id}, 32'd1);
    chk("br_flush_id_ex", {31'd0, bus.flush_id_ex}, 32'd1);
    tick();
    bus.branch_taken = 0;
    chk("br_pc", bus.pc, 32'h0040_0100);
    chk("br_state", {30'd0, bus.state}, 32'd2);
    chk("br_cnt", {16'd0, bus.redirect_count}, 32'd1);
    tick();
    bus.stall = 0;
    chk("br_stall_pc", bus.pc, 32'h0040_0100);
    chk("br_back_run", {30'd0, bus.state}, 32'd0);
    tick();
    chk("br_seq_pc", bus.pc, 32'h0040_0104);

    // exception + branch + jump together
    bus.exception = 1; bus.branch_taken = 1; bus.branch_target = 32'h0040_0200;
    bus.jump = 1; bus.jump_target = 32'h0040_0300;
    #1;
    chk("exc_flush_if_id", {31'd0, bus.flush_if_id}, 32'd1);
    chk("exc_flush_id_ex", {31'd0, bus.flush_id_ex}, 32'd1);
    tick();
    clear_in();
    chk("exc_pc", bus.pc, 32'h0040_0180);
    chk("exc_cnt", {16'd0, bus.redirect_count}, 32'd2);

    // misaligned branch
    bus.branch_taken = 1; bus.branch_target = 32'h0040_0102;
    tick();
    clear_in();
    chk("misalign_pc", bus.pc, 32'h0040_0180);
    chk("misalign_cnt", {16'd0, bus.redirect_count}, 32'd3);

    // halt, ignored jump, resume
    do_reset();
    repeat (4) tick();
    bus.halt = 1;
    #1;
    chk("halt_flush_if_id", {31'd0, bus.flush_if_id}, 32'd1);
    chk("halt_flush_id_ex", {31'd0, bus.flush_id_ex}, 32'd0);
    tick();
    bus.halt = 0;
    chk("halt_state", {30'd0, bus.state}, 32'd1);
    chk("halt_pc", bus.pc, 32'h0040_0010);
    chk("halt_fv", {31'd0, bus.fetch_valid}, 32'd0);
    bus.jump = 1; bus.jump_target = 32'h1234_5678;
    #1;
    chk("halt_jump_flush", {31'd0, bus.flush_if_id}, 32'd0);
    tick();
    bus.jump = 0;
    chk("halt_jump_pc", bus.pc, 32'h0040_0010);
    chk("halt_jump_cnt", {16'd0, bus.redirect_count}, 32'd0);
    bus.resume = 1;
    tick();
    bus.resume = 0;
    chk("resume_pc", bus.pc, 32'h0040_0014);
    chk("resume_state", {30'd0, bus.state}, 32'd0);
    chk("resume_fv", {31'd0, bus.fetch_valid}, 32'd1);

    // saturation and wrap
    bus.jump = 1; bus.jump_target = 32'hFFFF_FFFC;
    repeat (65535) tick();
    chk("sat_cnt_max", {16'd0, bus.redirect_count}, 32'h0000_FFFF);
    chk("sat_pc", bus.pc, 32'hFFFF_FFFC);
    tick();
    bus.jump = 0;
    chk("sat_cnt_hold", {16'd0, bus.redirect_count}, 32'h0000_FFFF);
    chk("wrap_plus4", bus.pc_plus4, 32'h0000_0000);
    tick();
    chk("wrap_pc", bus.pc, 32'h0000_0000);
    tick();
    chk("wrap_pc_next", bus.pc, 32'h0000_0004);
    bus.halt = 1;
    tick();
    bus.halt = 0;
    chk("halt2_state", {30'd0, bus.state}, 32'd1);
    do_reset();
    chk("halt_reset_pc", bus.pc, 32'h0040_0000);
    chk("halt_reset_state", {30'd0, bus.state}, 32'd0);
    chk("halt_reset_cnt", {16'd0, bus.redirect_count}, 32'd0);
    chk("halt_reset_fv", {31'd0, bus.fetch_valid}, 32'd1);

    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      reset            = ($urandom_range(0, 199) == 0);
      bus.stall        = ($urandom_range(0, 4) == 0);
      bus.jump         = ($urandom_range(0, 9) == 0);
      t = $urandom();
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      bus.jump_target  = t;
      bus.branch_taken = ($urandom_range(0, 9) == 0);
      t = $urandom();
      if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
      bus.branch_target = t;
      bus.exception    = ($urandom_range(0, 39) == 0);
      bus.halt         = ($urandom_range(0, 29) == 0);
      bus.resume       = ($urandom_range(0, 3) == 0);
      tick();
    end

    reset = 0;
    clear_in();
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter N, 32, PC and target width in bits.
REQ-002 Parameter RESET_PC, 32'h0040_0000, first fetch address after reset.
REQ-003 Parameter EXC_VECTOR, 32'h0040_0180, fetch address on exception.
REQ-004 clk  in  1  rising-edge clock; all state updates on this edge only.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 stall  in  1  hazard unit hold request (load-use); holds PC.
REQ-007 jump  in  1  ID-stage jump taken.
REQ-008 jump_target  in  N  ID-stage jump address.
REQ-009 branch_taken  in  1  EX-stage branch resolved taken.
REQ-010 branch_target  in  N  EX-stage branch address.
REQ-011 exception  in  1  external exception request.
REQ-012 halt  in  1  halt/syscall decoded in ID.
REQ-013 resume  in  1  leave HALTED state.
REQ-014 pc  out  N  current fetch PC, registered.
REQ-015 pc_plus4  out  N  pc + 4, combinational, modulo 2^N.
REQ-016 fetch_valid  out  1  registered; 1 when the instruction fetched at pc is valid.
REQ-017 flush_if_id  out  1  combinational; kill the IF/ID register at the next edge.
REQ-018 flush_id_ex  out  1  combinational; kill the ID/EX register at the next edge.
REQ-019 state  out  2  FSM state: RUN=0, HALTED=1, REDIRECT=2.
REQ-020 redirect_count  out  16  registered count of accepted redirects, saturating.

Function
REQ-021 Event priority in RUN and REDIRECT, highest first: exception, misaligned branch, branch_taken, jump, halt, stall, sequential.
REQ-022 Misaligned branch: branch_taken=1 with branch_target[1:0]!=0 is handled exactly as exception.
REQ-023 Exception: pc<=EXC_VECTOR; flush_if_id=1; flush_id_ex=1; state<=REDIRECT.
REQ-024 Branch taken (aligned): pc<=branch_target; flush_if_id=1; flush_id_ex=1; state<=REDIRECT.
REQ-025 Jump: pc<=jump_target; flush_if_id=1; flush_id_ex=0; state<=REDIRECT. Jump targets are not alignment-checked.
REQ-026 Halt: pc holds; flush_if_id=1; state<=HALTED; fetch_valid<=0.
REQ-027 Stall: pc, state and fetch_valid hold; both flushes 0.
REQ-028 Sequential: pc<=pc_plus4; state<=RUN; fetch_valid<=1.
REQ-029 A redirect (REQ-023/024/025) overrides a simultaneous stall.
REQ-030 REDIRECT lasts exactly one cycle with fetch_valid=1, then returns to RUN unless a new event occurs. A back-to-back redirect is accepted and counted.
REQ-031 HALTED: pc holds; fetch_valid=0; flushes 0; stall, jump, branch_taken and halt are ignored.
REQ-032 HALTED exits on exception (REQ-023 applies) or on resume: pc<=pc_plus4; state<=RUN; fetch_valid<=1. If both are asserted, exception wins.
REQ-033 redirect_count increments by 1 per accepted exception, branch or jump redirect. Halt does not increment it. The count saturates at 16'hFFFF.
REQ-034 pc_plus4 wraps: pc=32'hFFFF_FFFC gives pc_plus4=32'h0000_0000, and sequential fetch continues from 0.
REQ-035 Flush outputs are 0 whenever reset=1 or no event is accepted.

Reset
REQ-036 With reset=1 at a rising edge: pc<=RESET_PC; state<=RUN; fetch_valid<=1; redirect_count<=0.
REQ-037 Reset has priority over every input and is honoured in any state, including mid-REDIRECT and HALTED.
REQ-038 Asserting reset between edges has no effect on registered outputs until the next edge.

Verification
REQ-039 Reset, then 3 idle cycles -> pc sequence 0x400000, 0x400004, 0x400008, 0x40000C; fetch_valid=1; state=RUN.
REQ-040 At pc=0x400008, stall=1 for 2 cycles together with branch_taken=1 and branch_target=0x400100 in the 1st cycle -> flush_if_id=1 and flush_id_ex=1 that cycle; pc=0x400100 next; state=REDIRECT for 1 cycle; redirect_count=1.
REQ-041 Same cycle exception=1, branch_taken=1, jump=1 -> pc=0x400180; both flushes 1; redirect_count increments by exactly 1.
REQ-042 branch_taken=1 with branch_target=0x400102 -> pc=0x400180 (misaligned handled as exception).
REQ-043 halt=1 at pc=0x400010 -> state=HALTED; pc holds 0x400010; fetch_valid=0; jump ignored while halted; resume=1 -> pc=0x400014, state=RUN.
REQ-044 Force pc=0xFFFFFFFC via jump, then count up to 65535 redirects and apply one more -> next pc=0x0 and redirect_count stays at 0xFFFF; reset asserted while HALTED -> pc=0x400000, state=RUN.
